// File: rtl/smvm_stream_tx.sv
// Host-side transmitter for the SMVM engine serial input protocol.
// Loads a vector and a dense matrix, compresses nonzeros with row-start flags, then replays one gapless stream.
module smvm_stream_tx #(
   parameter int MAX_COLS = 128,
   parameter int MAX_NNZ  = 64,
   parameter int K        = 4,
   parameter int TAIL_GAP = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_valid,
   input  logic [7:0] cfg_rows,
   input  logic [7:0] cfg_cols,
   output logic       cfg_ready,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   output logic       s_ready,
   output logic [7:0] val_out,
   output logic [2:0] col_out,
   output logic       ipv_out,
   output logic       out_valid,
   output logic       busy,
   output logic       overflow,
   output logic [7:0] nnz_count
);

   localparam int VAW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
   localparam int EAW = (MAX_NNZ > 1) ? $clog2(MAX_NNZ) : 1;
   localparam int GW  = $clog2(TAIL_GAP + 1);
   localparam logic [8:0]    MAX_COLS_W = 9'(MAX_COLS);
   localparam logic [7:0]    MAX_NNZ_W  = 8'(MAX_NNZ);
   localparam logic [7:0]    K_W        = 8'(K);
   localparam logic [GW-1:0] GAP_LAST   = GW'(TAIL_GAP - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_LD_VEC, S_LD_MAT, S_PAD,
      S_TX_ROWS, S_TX_COLS, S_TX_VEC, S_TX_VAL, S_TX_IDX, S_DONE
   } state_t;

   typedef struct packed {
      logic [7:0] val;
      logic [7:0] col;
      logic       ipv;
   } entry_t;

   state_t        state_q, state_d;
   logic [7:0]    rows_q, rows_d, cols_q, cols_d;
   logic [7:0]    ccnt_q, ccnt_d, rcnt_q, rcnt_d;
   logic [7:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          row_nz_q, row_nz_d;

   logic          vec_we, ent_we, app, load_done, ov_set, ov_clr;
   entry_t        app_e, rd_e;
   logic [11:0]   word_d;
   logic          valid_d;

   logic [7:0]    vec [MAX_COLS];
   entry_t        ent [MAX_NNZ];

   wire cfg_hs   = cfg_valid & cfg_ready;
   wire s_hs     = s_valid & s_ready;
   wire last_col = (ccnt_q == cols_q - 8'd1);

   always_comb begin
      // NOTE: every variable gets a default before the case, otherwise missing branches infer latches.
      state_d   = state_q;
      rows_d    = rows_q;
      cols_d    = cols_q;
      ccnt_d    = ccnt_q;
      rcnt_d    = rcnt_q;
      row_nz_d  = row_nz_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      gap_d     = gap_q;
      vec_we    = 1'b0;
      ent_we    = 1'b0;
      app       = 1'b0;
      app_e     = '0;
      load_done = 1'b0;
      ov_set    = 1'b0;
      ov_clr    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cfg_hs && cfg_rows != 8'd0 && cfg_cols != 8'd0 && {1'b0, cfg_cols} <= MAX_COLS_W) begin
               rows_d   = cfg_rows;
               cols_d   = cfg_cols;
               ccnt_d   = '0;
               rcnt_d   = '0;
               row_nz_d = 1'b0;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               ov_clr   = 1'b1;
               state_d  = S_LD_VEC;
            end
         end
         S_LD_VEC: begin
            if (s_hs) begin
               vec_we = 1'b1;
               if (last_col) begin
                  ccnt_d  = '0;
                  state_d = S_LD_MAT;
               end else begin
                  ccnt_d = ccnt_q + 8'd1;
               end
            end
         end
         S_LD_MAT: begin
            if (s_hs) begin
               if (s_data != 8'd0) begin
                  app      = 1'b1;
                  app_e    = '{val: s_data, col: ccnt_q, ipv: ~row_nz_q};
                  row_nz_d = 1'b1;
               end else if (last_col && !row_nz_q) begin
                  // An all-zero row still needs one row-start marker for the engine.
                  app   = 1'b1;
                  app_e = '{val: 8'd0, col: 8'd0, ipv: 1'b1};
               end
               if (last_col) begin
                  ccnt_d    = '0;
                  row_nz_d  = 1'b0;
                  rcnt_d    = rcnt_q + 8'd1;
                  load_done = (rcnt_q == rows_q - 8'd1);
               end else begin
                  ccnt_d = ccnt_q + 8'd1;
               end
            end
         end
         S_PAD:     app = 1'b1;
         S_TX_ROWS: state_d = S_TX_COLS;
         S_TX_COLS: begin
            ccnt_d  = '0;
            state_d = S_TX_VEC;
         end
         S_TX_VEC: begin
            if (last_col) begin
               rd_ptr_d = '0;
               state_d  = S_TX_VAL;
            end else begin
               ccnt_d = ccnt_q + 8'd1;
            end
         end
         S_TX_VAL: state_d = S_TX_IDX;
         S_TX_IDX: begin
            if (rd_ptr_q == wr_ptr_q - 8'd1) begin
               gap_d   = '0;
               state_d = S_DONE;
            end else begin
               rd_ptr_d = rd_ptr_q + 8'd1;
               state_d  = S_TX_VAL;
            end
         end
         S_DONE: begin
            if (gap_q == GAP_LAST) state_d = S_IDLE;
            else                   gap_d   = gap_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (app) begin
         if (wr_ptr_q < MAX_NNZ_W) begin
            ent_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 8'd1;
         end else begin
            ov_set = 1'b1;
         end
      end

      // A full buffer is already a multiple of K, so padding stops there too.
      if (load_done || state_q == S_PAD)
         state_d = ((wr_ptr_d % K_W) != 8'd0) ? S_PAD : S_TX_ROWS;
   end

   // Next stream word, registered below so every output comes from a flop.
   always_comb begin
      word_d  = '0;
      valid_d = 1'b0;
      rd_e    = ent[rd_ptr_d[EAW-1:0]];
      case (state_d)
         S_TX_ROWS: begin valid_d = 1'b1; word_d = {4'b0, rows_q};                  end
         S_TX_COLS: begin valid_d = 1'b1; word_d = {4'b0, cols_q};                  end
         S_TX_VEC:  begin valid_d = 1'b1; word_d = {vec[ccnt_d[VAW-1:0]], 4'b0};    end
         S_TX_VAL:  begin valid_d = 1'b1; word_d = {rd_e.val, rd_e.ipv, 3'b000};    end
         S_TX_IDX:  begin valid_d = 1'b1; word_d = {4'b0, rd_e.col};                end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         rows_q    <= '0;
         cols_q    <= '0;
         ccnt_q    <= '0;
         rcnt_q    <= '0;
         row_nz_q  <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         gap_q     <= '0;
         cfg_ready <= 1'b0;
         s_ready   <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         val_out   <= '0;
         ipv_out   <= 1'b0;
         col_out   <= '0;
         overflow  <= 1'b0;
         nnz_count <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
         state_q   <= state_d;
         rows_q    <= rows_d;
         cols_q    <= cols_d;
         ccnt_q    <= ccnt_d;
         rcnt_q    <= rcnt_d;
         row_nz_q  <= row_nz_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         gap_q     <= gap_d;
         cfg_ready <= (state_d == S_IDLE);
         s_ready   <= (state_d == S_LD_VEC) || (state_d == S_LD_MAT);
         busy      <= (state_d != S_IDLE);
         out_valid <= valid_d;
         val_out   <= word_d[11:4];
         ipv_out   <= word_d[3];
         col_out   <= word_d[2:0];
         overflow  <= (overflow & ~ov_clr) | ov_set;
         nnz_count <= wr_ptr_d;
      end
   end

   // NOTE: buffers are not reset; wr_ptr bounds what is valid, so a reset empties them logically.
   always_ff @(posedge clk) begin
      if (vec_we) vec[ccnt_q[VAW-1:0]]   <= s_data;
      if (ent_we) ent[wr_ptr_q[EAW-1:0]] <= app_e;
   end

endmodule

// File: tb/tb_smvm_stream_tx.sv
// Self-checking bench for smvm_stream_tx: directed jobs plus random jobs against a queue-based stream model.
module tb_smvm_stream_tx;
   localparam int MAX_COLS = 128;
   localparam int MAX_NNZ  = 64;
   localparam int K        = 4;
   localparam int TAIL_GAP = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_valid;
   logic [7:0] cfg_rows, cfg_cols;
   logic       cfg_ready;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic [7:0] val_out;
   logic [2:0] col_out;
   logic       ipv_out, out_valid, busy, overflow;
   logic [7:0] nnz_count;

   always #5 clk = ~clk;

   smvm_stream_tx #(.MAX_COLS(MAX_COLS), .MAX_NNZ(MAX_NNZ), .K(K), .TAIL_GAP(TAIL_GAP)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_ready(cfg_ready),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .val_out(val_out), .col_out(col_out), .ipv_out(ipv_out), .out_valid(out_valid),
      .busy(busy), .overflow(overflow), .nnz_count(nnz_count)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Job data and reference model state
   logic [7:0]  tv [MAX_COLS];
   logic [7:0]  tm [2048];
   logic [11:0] exp_q[$];
   logic [11:0] got_q[$];
   logic [7:0]  ent_val[$];
   logic [7:0]  ent_col[$];
   logic        ent_ipv[$];
   logic        exp_ovf;
   int          exp_pad, exp_nnz;
   int          got_nnz, got_ovf;

   task automatic add_ent(input logic [7:0] v, input logic [7:0] c, input logic p);
      if (ent_val.size() < MAX_NNZ) begin
         ent_val.push_back(v);
         ent_col.push_back(c);
         ent_ipv.push_back(p);
      end else begin
         exp_ovf = 1'b1;
      end
   endtask

   task automatic build_model(input int rows, input int cols);
      bit seen;
      exp_q.delete(); ent_val.delete(); ent_col.delete(); ent_ipv.delete();
      exp_ovf = 1'b0;
      for (int r = 0; r < rows; r++) begin
         seen = 1'b0;
         for (int c = 0; c < cols; c++) begin
            if (tm[r*cols + c] != 8'd0) begin
               add_ent(tm[r*cols + c], 8'(c), !seen);
               seen = 1'b1;
            end
         end
         if (!seen) add_ent(8'd0, 8'd0, 1'b1);
      end
      exp_pad = 0;
      if (ent_val.size() < MAX_NNZ)
         while (ent_val.size() % K != 0) begin
            add_ent(8'd0, 8'd0, 1'b0);
            exp_pad++;
         end
      exp_nnz = ent_val.size();
      exp_q.push_back({4'b0, 8'(rows)});
      exp_q.push_back({4'b0, 8'(cols)});
      for (int i = 0; i < cols; i++) exp_q.push_back({tv[i], 4'b0});
      for (int e = 0; e < exp_nnz; e++) begin
         exp_q.push_back({ent_val[e], ent_ipv[e], 3'b000});
         exp_q.push_back({4'b0, ent_col[e]});
      end
   endtask

   task automatic send(input logic [7:0] v, input int gap);
      int w;
      s_valid = 1'b0;
      repeat (gap) @(negedge clk);
      s_valid = 1'b1;
      s_data  = v;
      w = 0;
      while (!s_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) check("s_ready_wait", 32'(w), 0);
      @(negedge clk);
   endtask

   task automatic load_job(input int rows, input int cols, input int gap);
      build_model(rows, cols);
      @(negedge clk);
      check("cfg_ready_idle", {31'd0, cfg_ready}, 1);
      cfg_valid = 1'b1;
      cfg_rows  = 8'(rows);
      cfg_cols  = 8'(cols);
      @(negedge clk);
      check("busy_after_cfg", {31'd0, busy}, 1);
      if (gap > 0) begin
         // Bogus header while busy must be ignored
         cfg_rows = 8'd9;
         cfg_cols = 8'd1;
      end else begin
         cfg_valid = 1'b0;
      end
      for (int i = 0; i < cols; i++)        send(tv[i], gap);
      for (int i = 0; i < rows * cols; i++) send(tm[i], gap);
      s_valid   = 1'b0;
      cfg_valid = 1'b0;
   endtask

   task automatic collect();
      int lat, len, tail, tail_bad;
      got_q.delete();
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("start_latency", 32'(lat), 32'(exp_pad));
      got_nnz = nnz_count;
      got_ovf = overflow;
      check("nnz_count", 32'(got_nnz), 32'(exp_nnz));
      check("overflow", 32'(got_ovf), {31'd0, exp_ovf});
      len = 0;
      while (out_valid && len < 4000) begin
         got_q.push_back({val_out, ipv_out, col_out});
         if (len < exp_q.size()) check($sformatf("word[%0d]", len), {20'd0, val_out, ipv_out, col_out}, {20'd0, exp_q[len]});
         len++;
         @(negedge clk);
      end
      check("stream_len", 32'(len), 32'(exp_q.size()));
      tail = 0;
      tail_bad = 0;
      while (!cfg_ready && tail < 100) begin
         if (out_valid || val_out != 0 || col_out != 0 || ipv_out) tail_bad++;
         tail++;
         @(negedge clk);
      end
      check("tail_len", 32'(tail), 32'(TAIL_GAP));
      check("tail_quiet", 32'(tail_bad), 0);
   endtask

   task automatic set_basic();
      tv[0] = 8'd1; tv[1] = 8'd2; tv[2] = 8'd3;
      tm[0] = 8'd0;  tm[1] = 8'd5; tm[2] = 8'd0;
      tm[3] = 8'hFD; tm[4] = 8'd0; tm[5] = 8'd2;
   endtask

   task automatic rand_job(input int rows, input int cols, input int gap);
      for (int i = 0; i < cols; i++) tv[i] = 8'($urandom);
      for (int i = 0; i < rows * cols; i++)
         tm[i] = ($urandom_range(0, 99) < 55) ? 8'd0 : 8'($urandom);
      load_job(rows, cols, gap);
      collect();
   endtask

   initial begin
      int w;
      rst = 1'b1; cfg_valid = 1'b0; cfg_rows = '0; cfg_cols = '0; s_valid = 1'b0; s_data = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {12'd0, out_valid, cfg_ready, busy, s_ready, overflow, ipv_out, col_out, val_out, nnz_count}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", {30'd0, cfg_ready, busy}, 2);

      // Basic job
      set_basic();
      load_job(2, 3, 0);
      collect();
      check("basic_len", 32'(got_q.size()), 13);
      check("basic_nnz", 32'(got_nnz), 4);
      if (got_q.size() > 5) check("basic_first_val", {20'd0, got_q[5]}, 32'h058);

      // Empty row
      tv[0] = 8'd1; tv[1] = 8'd1;
      tm[0] = 8'd0; tm[1] = 8'd0; tm[2] = 8'd4; tm[3] = 8'd0;
      load_job(2, 2, 0);
      collect();
      check("empty_row_nnz", 32'(got_nnz), 4);

      // Load gaps
      set_basic();
      load_job(2, 3, 3);
      collect();
      check("gap_len", 32'(got_q.size()), 13);

      // Overflow
      for (int i = 0; i < 9; i++)  tv[i] = 8'(i + 1);
      for (int i = 0; i < 72; i++) tm[i] = 8'd1;
      load_job(8, 9, 0);
      collect();
      check("ovf_flag", 32'(got_ovf), 1);
      check("ovf_nnz", 32'(got_nnz), 64);
      if (got_q.size() > 0) check("ovf_last_idx", {20'd0, got_q[got_q.size()-1]}, 0);

      // Reset mid-stream during TX_VEC
      set_basic();
      load_job(2, 3, 0);
      w = 0;
      while (!out_valid && w < 50) begin
         @(negedge clk);
         w++;
      end
      repeat (2) @(negedge clk);
      check("mid_vec0", {24'd0, val_out}, 1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_outputs", {29'd0, out_valid, busy, cfg_ready}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("abort_ready", {30'd0, cfg_ready, busy}, 2);
      set_basic();
      load_job(2, 3, 0);
      collect();

      // Bad configs
      @(negedge clk);
      cfg_valid = 1'b1; cfg_rows = 8'd0; cfg_cols = 8'd3;
      @(negedge clk);
      check("bad_rows0", {30'd0, cfg_ready, busy}, 2);
      cfg_rows = 8'd2; cfg_cols = 8'd129;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("bad_cols129", {30'd0, cfg_ready, busy}, 2);
      repeat (2) @(negedge clk);
      check("bad_cfg_idle", {29'd0, cfg_ready, busy, s_ready}, 4);

      // Random jobs, including the widest vector
      for (int j = 0; j < 6; j++)
         rand_job($urandom_range(1, 8), $urandom_range(1, 12), $urandom_range(0, 2));
      rand_job(1, MAX_COLS, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
